instruction_encoder: RTL and testbench

- Inverse of the instruction decoder: takes field-level instruction requests (format, opcode, funct3/funct7, rs1/rs2/rd, full-width immediate) over a valid/ready handshake.
- Packs each request into a 32-bit RV32I word (R/I/S/B/U/J) and checks immediate range and alignment.
- Writes each valid word sequentially into instruction memory through a valid/ready write port.
- Used as the debug/boot program loader that fills instruction memory ahead of core execution.

---
 rtl/instruction_encoder_pkg.sv | 39 +++
 rtl/instruction_encoder_packer.sv | 54 +++++
 rtl/instruction_encoder.sv | 127 ++++++++++++
 tb/tb_instruction_encoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I encoding constants: format selectors, error codes, opcodes,
// loader FSM states and the signed-immediate range helper.
package rv32_encoder_defs;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_FMT      = 2'b11;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  // True when imm[31:msb] are all equal, i.e. the value is representable as a
  // signed immediate whose sign bit sits at position msb.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << msb;
    return ((imm & mask) == mask) || ((imm & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/instruction_encoder_packer.sv
// Combinational RV32I field packer: places fields and immediate bits for the
// selected format and reports the first failing immediate/format check.
module instr_field_packer
  import rv32_encoder_defs::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic [1:0]  err_code_o,
  output logic        err_o
);

  // NOTE: every output of a combinational block gets a default first so that
  // no path through the case leaves it unassigned and infers a latch.
  always_comb begin
    word_o     = 32'h0;
    err_code_o = ERR_NONE;
    case (fmt_i)
      FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        if (!imm_fits(imm_i, 11)) err_code_o = ERR_RANGE;
      end
      FMT_S: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        if (!imm_fits(imm_i, 11)) err_code_o = ERR_RANGE;
      end
      FMT_B: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                  imm_i[4:1], imm_i[11], opcode_i};
        if (imm_i[0])                 err_code_o = ERR_MISALIGN;
        else if (!imm_fits(imm_i, 12)) err_code_o = ERR_RANGE;
      end
      FMT_U: begin
        word_o = {imm_i[31:12], rd_i, opcode_i};
        if (imm_i[11:0] != 12'h0) err_code_o = ERR_RANGE;
      end
      FMT_J: begin
        word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        if (imm_i[0])                 err_code_o = ERR_MISALIGN;
        else if (!imm_fits(imm_i, 20)) err_code_o = ERR_RANGE;
      end
      default: err_code_o = ERR_FMT;
    endcase
    err_o = (err_code_o != ERR_NONE);
  end

endmodule

// File: rtl/instruction_encoder.sv
// Program loader: accepts field-level instruction requests, encodes them and
// streams the words into instruction memory at a sequential write pointer.
module instruction_encoder
  import rv32_encoder_defs::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    ADDR_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_fmt,
  input  logic [6:0]            req_opcode,
  input  logic [2:0]            req_funct3,
  input  logic [6:0]            req_funct7,
  input  logic [4:0]            req_rs1,
  input  logic [4:0]            req_rs2,
  input  logic [4:0]            req_rd,
  input  logic [31:0]           req_imm,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [31:0]           mem_wr_data,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic [15:0]           words_written,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [31:0]           data_q, data_d;
  logic [1:0]            code_q, code_d;
  logic [15:0]           count_q, count_d;
  logic                  armed_q;

  logic [31:0] pk_word;
  logic [1:0]  pk_code;
  logic        pk_err;

  instr_field_packer u_packer (
    .fmt_i      (req_fmt),
    .opcode_i   (req_opcode),
    .funct3_i   (req_funct3),
    .funct7_i   (req_funct7),
    .rs1_i      (req_rs1),
    .rs2_i      (req_rs2),
    .rd_i       (req_rd),
    .imm_i      (req_imm),
    .word_o     (pk_word),
    .err_code_o (pk_code),
    .err_o      (pk_err)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    code_d    = code_q;
    count_d   = count_q;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // armed_q keeps req_ready low until the first edge after reset release.
        if (armed_q) begin
          if (addr_load) begin
            ptr_d = start_addr;
          end else begin
            req_ready = 1'b1;
            if (req_valid) begin
              if (pk_err) begin
                code_d  = pk_code;
                state_d = ST_ERROR;
              end else begin
                data_d  = pk_word;
                state_d = ST_WRITE;
              end
            end
          end
        end
      end
      ST_WRITE: begin
        if (mem_wr_ready) begin
          ptr_d   = ptr_q + ADDR_WIDTH'(ADDR_STEP);
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= BASE_ADDR;
      data_q  <= 32'h0;
      code_q  <= ERR_NONE;
      count_q <= 16'h0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      code_q  <= code_d;
      count_q <= count_d;
      armed_q <= 1'b1;
    end
  end

  // The pointer only moves in IDLE, so the address is stable throughout WRITE.
  assign mem_wr_valid  = (state_q == ST_WRITE);
  assign mem_wr_addr   = ptr_q;
  assign mem_wr_data   = data_q;
  assign err_valid     = (state_q == ST_ERROR);
  assign err_code      = err_valid ? code_q : ERR_NONE;
  assign words_written = count_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: the driver queues hand-computed
// expected writes/errors, the monitor compares whenever the DUT presents one.
module tb_instruction_encoder;
  import rv32_encoder_defs::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        addr_load = 1'b0;
  logic [31:0] start_addr = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_fmt = '0;
  logic [6:0]  req_opcode = '0;
  logic [2:0]  req_funct3 = '0;
  logic [6:0]  req_funct7 = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] req_imm = '0;
  logic        mem_wr_valid;
  logic        mem_wr_ready = 1'b1;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] words_written;
  logic        busy;

  typedef struct packed {
    logic        is_err;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  code;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic err_prev = 1'b0;

  instruction_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0), .ADDR_STEP(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .addr_load     (addr_load),
    .start_addr    (start_addr),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_fmt       (req_fmt),
    .req_opcode    (req_opcode),
    .req_funct3    (req_funct3),
    .req_funct7    (req_funct7),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_rd        (req_rd),
    .req_imm       (req_imm),
    .mem_wr_valid  (mem_wr_valid),
    .mem_wr_ready  (mem_wr_ready),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .err_valid     (err_valid),
    .err_code      (err_code),
    .words_written (words_written),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic exp_t wexp(input logic [31:0] addr, input logic [31:0] data);
    return '{is_err: 1'b0, addr: addr, data: data, code: 2'b00};
  endfunction

  function automatic exp_t eexp(input logic [1:0] code);
    return '{is_err: 1'b1, addr: 32'h0, data: 32'h0, code: code};
  endfunction

  // Monitor: compares every presented write/error against the queue head.
  always @(negedge clk) begin
    if (!reset_n) begin
      err_prev = 1'b0;
    end else begin
      if (mem_wr_valid) begin
        if (exp_q.size() == 0 || exp_q[0].is_err) begin
          flag($sformatf("unexpected_write addr=%h data=%h", mem_wr_addr, mem_wr_data));
        end else begin
          check("wr_addr", mem_wr_addr, exp_q[0].addr);
          check("wr_data", mem_wr_data, exp_q[0].data);
          if (mem_wr_ready) void'(exp_q.pop_front());
        end
      end
      if (err_valid) begin
        if (err_prev) flag("err_pulse_longer_than_one_cycle");
        if (exp_q.size() == 0 || !exp_q[0].is_err) begin
          flag($sformatf("unexpected_error code=%b", err_code));
        end else begin
          check("err_code", 32'(err_code), 32'(exp_q[0].code));
          void'(exp_q.pop_front());
        end
      end
      err_prev = err_valid;
    end
  end

  task automatic issue(input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm, input exp_t e);
    int n;
    @(posedge clk); #1;
    req_fmt = fmt; req_opcode = opc; req_funct3 = f3; req_funct7 = f7;
    req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_imm = imm;
    req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 20) break;
    end
    if (n > 20) flag("req_ready_timeout");
    else exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 40) break;
    end
    if (n > 40) flag("busy_timeout");
  endtask

  initial begin
    // Reset values while reset is held.
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_wr_valid", 32'(mem_wr_valid), 32'd0);
    check("rst_wr_addr", mem_wr_addr, 32'h0);
    check("rst_wr_data", mem_wr_data, 32'h0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // R-type: sub x17, x10, x21
    issue(FMT_R, OP, 3'b000, 7'b0100000, 5'd10, 5'd21, 5'd17, 32'hDEAD_BEEF,
          wexp(32'h0, 32'h4155_08B3));
    wait_idle();
    check("words_after_r", 32'(words_written), 32'd1);

    // addr_load wins over a simultaneous request.
    @(posedge clk); #1;
    addr_load = 1'b1; start_addr = 32'h100;
    req_fmt = FMT_R; req_opcode = OP; req_valid = 1'b1;
    @(negedge clk);
    check("load_blocks_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    addr_load = 1'b0; req_valid = 1'b0;
    check("load_no_accept", 32'(busy), 32'd0);
    check("load_ptr", mem_wr_addr, 32'h100);

    // B-type beq x1,x2,-4 ; J-type jal x1,0x800 (unused fields driven nonzero)
    issue(FMT_B, BRANCH, 3'b000, 7'h7F, 5'd1, 5'd2, 5'd31, 32'hFFFF_FFFC,
          wexp(32'h100, 32'hFE20_8EE3));
    wait_idle();
    issue(FMT_J, JAL, 3'b011, 7'h55, 5'd5, 5'd9, 5'd1, 32'h0000_0800,
          wexp(32'h104, 32'h0010_00EF));
    wait_idle();
    check("words_after_bj", 32'(words_written), 32'd3);

    // Rejected requests: code, no write, pointer and count unchanged.
    issue(FMT_B, BRANCH, 3'b000, 7'h0, 5'd1, 5'd2, 5'd0, 32'd3, eexp(ERR_MISALIGN));
    wait_idle();
    check("err_b_ptr", mem_wr_addr, 32'h108);
    issue(FMT_I, OP_IMM, 3'b000, 7'h0, 5'd6, 5'd0, 5'd5, 32'd2048, eexp(ERR_RANGE));
    wait_idle();
    issue(FMT_J, JAL, 3'b000, 7'h0, 5'd0, 5'd0, 5'd1, 32'h0010_0000, eexp(ERR_RANGE));
    wait_idle();
    issue(FMT_U, LUI, 3'b000, 7'h0, 5'd0, 5'd0, 5'd1, 32'h0000_1001, eexp(ERR_RANGE));
    wait_idle();
    issue(3'd7, OP, 3'b000, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0, eexp(ERR_FMT));
    wait_idle();
    check("err_ptr", mem_wr_addr, 32'h108);
    check("err_words", 32'(words_written), 32'd3);

    // Legal boundary immediates: addi x5,x6,-2048 ; sw x7,-4(x2)
    issue(FMT_I, OP_IMM, 3'b000, 7'h7F, 5'd6, 5'd31, 5'd5, 32'hFFFF_F800,
          wexp(32'h108, 32'h8003_0293));
    wait_idle();
    issue(FMT_S, STORE, 3'b010, 7'h7F, 5'd2, 5'd7, 5'd31, 32'hFFFF_FFFC,
          wexp(32'h10C, 32'hFE71_2E23));
    wait_idle();

    // Backpressure: lui x10,0x12345 held three cycles; addr_load ignored.
    mem_wr_ready = 1'b0;
    issue(FMT_U, LUI, 3'b000, 7'h0, 5'd0, 5'd0, 5'd10, 32'h1234_5000,
          wexp(32'h110, 32'h1234_5537));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_wr_valid", 32'(mem_wr_valid), 32'd1);
      addr_load  = (i == 1);
      start_addr = 32'h200;
    end
    @(posedge clk); #1;
    addr_load = 1'b0;
    mem_wr_ready = 1'b1;
    wait_idle();
    check("bp_ptr", mem_wr_addr, 32'h114);
    check("bp_words", 32'(words_written), 32'd6);

    // Reset while a write is stalled.
    mem_wr_ready = 1'b0;
    issue(FMT_R, OP, 3'b000, 7'h0, 5'd1, 5'd2, 5'd3, 32'h0,
          wexp(32'h114, 32'h0020_81B3));
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_wr_valid", 32'(mem_wr_valid), 32'd0);
    exp_q.delete();
    @(posedge clk); #2;
    reset_n = 1'b1;
    mem_wr_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ptr", mem_wr_addr, 32'h0);
    check("rst_mid_words", 32'(words_written), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);

    // Pointer wrap: lui x1,0xFFFFF at the top of the address space.
    @(posedge clk); #1;
    addr_load = 1'b1; start_addr = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    addr_load = 1'b0;
    issue(FMT_U, LUI, 3'b000, 7'h0, 5'd0, 5'd0, 5'd1, 32'hFFFF_F000,
          wexp(32'hFFFF_FFFC, 32'hFFFF_F0B7));
    wait_idle();
    check("wrap_ptr", mem_wr_addr, 32'h0);
    check("wrap_words", 32'(words_written), 32'd1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
